// File: rtl/pattern_det_scheduler_pkg.sv
// Shared types for the pattern-detector scheduler: control FSM states, detector
// states, the serial pattern and the detector transition function.
package pattern_det_scheduler_pkg;

   localparam int unsigned PAT_W = 5;
   localparam logic [PAT_W-1:0] PATTERN = 5'b10010;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_SHIFT = 3'd2,
      ST_FLUSH = 3'd3,
      ST_DONE  = 3'd4
   } sched_state_e;

   typedef enum logic [2:0] {
      DET_A = 3'd0,
      DET_B = 3'd1,
      DET_C = 3'd2,
      DET_D = 3'd3,
      DET_E = 3'd4,
      DET_F = 3'd5
   } det_state_e;

   // A..E advance on the expected pattern bit; otherwise fall back to the longest
   // prefix that is still a suffix of the bits seen. F (match) overlaps into B/D.
   function automatic det_state_e det_next(input det_state_e s, input logic j);
      det_state_e nxt;
      if (3'(s) > 3'(DET_F)) begin
         nxt = DET_A;
      end else if (s == DET_F) begin
         nxt = j ? DET_B : DET_D;
      end else if (j == PATTERN[3'(PAT_W - 1) - 3'(s)]) begin
         nxt = det_state_e'(3'(s) + 3'd1);
      end else begin
         nxt = j ? DET_B : DET_A;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/pattern_det_moore.sv
// Six-state Moore detector for 1-0-0-1-0 with overlap; w is high while in state F.
module pattern_det_moore
   import pattern_det_scheduler_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic j,
   output logic w
);

   det_state_e state_q, state_d;
   logic       w_q;

   always_comb begin
      state_d = det_next(state_q, j);
      if (clr) begin
         state_d = DET_A;
      end
   end

   // Flag is registered from the next state so it equals (state_q == F).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= DET_A;
         w_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         w_q     <= (state_d == DET_F);
      end
   end

   assign w = w_q;

endmodule

// File: rtl/pattern_det_scheduler.sv
// Round-robin scheduler sharing one serial 1-0-0-1-0 detector among N clients;
// returns the overlapping match count of each granted word with a done pulse.
module pattern_det_scheduler
   import pattern_det_scheduler_pkg::*;
#(
   parameter int unsigned N      = 4,
   parameter int unsigned WORD_W = 8,
   parameter int unsigned CNT_W  = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N-1:0]           req,
   input  logic [N*WORD_W-1:0]    data_i,
   output logic [N-1:0]           gnt,
   output logic                   busy,
   output logic                   done,
   output logic [$clog2(N)-1:0]   done_id,
   output logic [CNT_W-1:0]       match_cnt
);

   localparam int unsigned ID_W  = $clog2(N);
   localparam int unsigned BIT_W = $clog2(WORD_W);

   sched_state_e      state_q, state_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic [WORD_W-1:0] sr_q, sr_d;
   logic [BIT_W-1:0]  bit_q, bit_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [N-1:0]      gnt_q, gnt_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [ID_W-1:0]   done_id_q, done_id_d;
   logic [CNT_W-1:0]  match_cnt_q, match_cnt_d;

   logic              arb_found;
   logic [ID_W-1:0]   arb_idx;
   logic [ID_W-1:0]   arb_cand;
   logic [WORD_W-1:0] word_sel;
   logic [CNT_W-1:0]  cnt_inc;
   logic              det_clr_c;
   logic              det_j_c;
   logic              det_w;

   // Round-robin: scan downward so the candidate closest to ptr_q wins.
   always_comb begin
      arb_found = 1'b0;
      arb_idx   = '0;
      arb_cand  = '0;
      for (int k = int'(N) - 1; k >= 0; k--) begin
         arb_cand = ID_W'((int'(ptr_q) + k) % int'(N));
         if (req[arb_cand]) begin
            arb_found = 1'b1;
            arb_idx   = arb_cand;
         end
      end
   end

   always_comb begin
      word_sel = '0;
      for (int i = 0; i < int'(N); i++) begin
         if (id_q == ID_W'(i)) begin
            word_sel = data_i[i*WORD_W +: WORD_W];
         end
      end
   end

   assign cnt_inc = (det_w && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;

   pattern_det_moore u_det (
      .clk (clk),
      .rst (rst),
      .clr (det_clr_c),
      .j   (det_j_c),
      .w   (det_w)
   );

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      id_d        = id_q;
      sr_d        = sr_q;
      bit_d       = bit_q;
      cnt_d       = cnt_q;
      gnt_d       = '0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      done_id_d   = done_id_q;
      match_cnt_d = match_cnt_q;
      det_clr_c   = 1'b0;
      det_j_c     = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (arb_found) begin
               state_d = ST_LOAD;
               id_d    = arb_idx;
               ptr_d   = (arb_idx == ID_W'(N - 1)) ? '0 : arb_idx + ID_W'(1);
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOAD: begin
            det_clr_c = 1'b1;
            sr_d      = word_sel;
            bit_d     = '0;
            cnt_d     = '0;
            state_d   = ST_SHIFT;
         end
         ST_SHIFT: begin
            det_j_c = sr_q[WORD_W-1];
            sr_d    = sr_q << 1;
            cnt_d   = cnt_inc;
            if (bit_q == BIT_W'(WORD_W - 1)) begin
               state_d = ST_FLUSH;
            end else begin
               bit_d = bit_q + BIT_W'(1);
            end
         end
         ST_FLUSH: begin
            cnt_d   = cnt_inc;
            state_d = ST_DONE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Outputs are registered from the next state so they line up with it.
      if (state_d == ST_LOAD) begin
         gnt_d[id_d] = 1'b1;
      end
      busy_d = (state_d == ST_LOAD) || (state_d == ST_SHIFT) || (state_d == ST_FLUSH);
      if (state_d == ST_DONE) begin
         done_d      = 1'b1;
         done_id_d   = id_q;
         match_cnt_d = cnt_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         id_q        <= '0;
         sr_q        <= '0;
         bit_q       <= '0;
         cnt_q       <= '0;
         gnt_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         done_id_q   <= '0;
         match_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         id_q        <= id_d;
         sr_q        <= sr_d;
         bit_q       <= bit_d;
         cnt_q       <= cnt_d;
         gnt_q       <= gnt_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         done_id_q   <= done_id_d;
         match_cnt_q <= match_cnt_d;
      end
   end

   assign gnt       = gnt_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign done_id   = done_id_q;
   assign match_cnt = match_cnt_q;

endmodule
